// File: rtl/async_operator_fifo.sv
// Dataflow operator: pulls one token per input channel, applies op, and queues the
// result in a DEPTH-entry FIFO. Each output channel reads every result once, at its own pace.
module async_operator_fifo #(
   parameter int unsigned             data_width  = 32,
   parameter string                   op          = "add",
   parameter logic [data_width-1:0]   immediate   = {data_width{1'b0}},
   parameter int unsigned             input_size  = 2,
   parameter int unsigned             output_size = 2,
   parameter int unsigned             depth       = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic [input_size-1:0]              req_l,
   input  logic [input_size-1:0]              ack_l,
   input  logic [data_width*input_size-1:0]   din,
   input  logic [output_size-1:0]             req_r,
   output logic [output_size-1:0]             ack_r,
   output logic [data_width*output_size-1:0]  dout,
   output logic [$clog2(depth):0]             level,
   output logic                               full,
   output logic                               err
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [PW-1:0] DEPTH_P  = PW'(depth);

   localparam logic [3:0] OP_SEL =
      (op == "addi") ? 4'd1  : (op == "subi") ? 4'd2  : (op == "muli") ? 4'd3  :
      (op == "add")  ? 4'd4  : (op == "sub")  ? 4'd5  : (op == "mul")  ? 4'd6  :
      (op == "and")  ? 4'd7  : (op == "or")   ? 4'd8  : (op == "xor")  ? 4'd9  :
      (op == "min")  ? 4'd10 : (op == "max")  ? 4'd11 : 4'd0;

   // Left fold from channel 0; immediate ops only ever see d0.
   function automatic logic [data_width-1:0] apply_op(input logic [data_width*input_size-1:0] v);
      logic [data_width-1:0] acc_s;
      logic [data_width-1:0] d_s;
      acc_s = v[data_width-1:0];
      case (OP_SEL)
         4'd1:    acc_s = acc_s + immediate;
         4'd2:    acc_s = acc_s - immediate;
         4'd3:    acc_s = acc_s * immediate;
         default: acc_s = acc_s;
      endcase
      for (int i = 1; i < int'(input_size); i++) begin
         d_s = v[data_width*i +: data_width];
         case (OP_SEL)
            4'd4:    acc_s = acc_s + d_s;
            4'd5:    acc_s = acc_s - d_s;
            4'd6:    acc_s = acc_s * d_s;
            4'd7:    acc_s = acc_s & d_s;
            4'd8:    acc_s = acc_s | d_s;
            4'd9:    acc_s = acc_s ^ d_s;
            4'd10:   acc_s = (d_s < acc_s) ? d_s : acc_s;
            4'd11:   acc_s = (d_s > acc_s) ? d_s : acc_s;
            default: acc_s = acc_s;
         endcase
      end
      return acc_s;
   endfunction

   logic [input_size-1:0]             has_r;
   logic [input_size-1:0]             req_l_r;
   logic [data_width*input_size-1:0]  tok_r;
   logic                              err_r;
   logic [data_width-1:0]             mem_r [depth];
   logic [PW-1:0]                     wr_ptr_r;
   logic [PW-1:0]                     rd_ptr_r [output_size];
   logic [output_size-1:0]            ack_r_r;
   logic [data_width*output_size-1:0] dout_r;
   logic [PW-1:0]                     level_r;
   logic                              full_r;

   logic [PW-1:0]                     avail_s   [output_size];
   logic [PW-1:0]                     rd_next_s [output_size];
   logic [output_size-1:0]            pop_s;
   logic [PW-1:0]                     wr_next_s;
   logic [PW-1:0]                     level_now_s;
   logic [PW-1:0]                     level_next_s;
   logic                              push_s;

   // Pop decisions and occupancy: current level gates the push, next level is registered.
   always_comb begin
      level_now_s  = PTR_ZERO;
      level_next_s = PTR_ZERO;
      for (int j = 0; j < int'(output_size); j++) begin
         avail_s[j]   = wr_ptr_r - rd_ptr_r[j];
         pop_s[j]     = req_r[j] & ~ack_r_r[j] & (avail_s[j] != PTR_ZERO);
         rd_next_s[j] = pop_s[j] ? (rd_ptr_r[j] + PTR_ONE) : rd_ptr_r[j];
         if (avail_s[j] > level_now_s) begin
            level_now_s = avail_s[j];
         end else begin
            level_now_s = level_now_s;
         end
      end
      push_s    = (&has_r) & (level_now_s != DEPTH_P);
      wr_next_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      for (int j = 0; j < int'(output_size); j++) begin
         if ((wr_next_s - rd_next_s[j]) > level_next_s) begin
            level_next_s = wr_next_s - rd_next_s[j];
         end else begin
            level_next_s = level_next_s;
         end
      end
   end

   // Input pull handshake: capture on ack, release the slot once the result is pushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         has_r   <= {input_size{1'b0}};
         req_l_r <= {input_size{1'b0}};
         tok_r   <= {(data_width*input_size){1'b0}};
         err_r   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(input_size); i++) begin
            if (ack_l[i] && req_l_r[i]) begin
               tok_r[data_width*i +: data_width] <= din[data_width*i +: data_width];
               has_r[i]   <= 1'b1;
               req_l_r[i] <= 1'b0;
            end else if (push_s) begin
               has_r[i] <= 1'b0;
            end else if (!has_r[i] && !req_l_r[i]) begin
               req_l_r[i] <= 1'b1;
            end
         end
         if (|(ack_l & ~req_l_r)) begin
            err_r <= 1'b1;
         end
      end
   end

   // Result storage needs no reset: entries are only read once the write pointer passes them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= apply_op(tok_r);
      end
   end

   // Pointers, per-output ack/data and registered occupancy flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= PTR_ZERO;
         for (int j = 0; j < int'(output_size); j++) begin
            rd_ptr_r[j] <= PTR_ZERO;
         end
         ack_r_r <= {output_size{1'b0}};
         dout_r  <= {(data_width*output_size){1'b0}};
         level_r <= PTR_ZERO;
         full_r  <= 1'b0;
      end else begin
         wr_ptr_r <= wr_next_s;
         for (int j = 0; j < int'(output_size); j++) begin
            rd_ptr_r[j] <= rd_next_s[j];
            ack_r_r[j]  <= pop_s[j];
            if (pop_s[j]) begin
               dout_r[data_width*j +: data_width] <= mem_r[rd_ptr_r[j][AW-1:0]];
            end
         end
         level_r <= level_next_s;
         full_r  <= (level_next_s == DEPTH_P);
      end
   end

   assign req_l = req_l_r;
   assign ack_r = ack_r_r;
   assign dout  = dout_r;
   assign level = level_r;
   assign full  = full_r;
   assign err   = err_r;

endmodule

// File: tb/tb_async_operator_fifo.sv
// Scoreboard bench: stimulus pushes expected results per output, a negedge monitor
// pops and compares whenever an output acks.
module tb_async_operator_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // add, 2 in / 2 out, depth 4
   logic [1:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
   logic [63:0] a_din, a_dout;
   logic [2:0]  a_level;
   logic        a_full, a_err;
   // addi +2, 1 in / 2 out, depth 2
   logic [0:0]  i_req_l, i_ack_l;
   logic [1:0]  i_req_r, i_ack_r;
   logic [31:0] i_din;
   logic [63:0] i_dout;
   logic [1:0]  i_level;
   logic        i_full, i_err;
   // sub, 3 in / 1 out
   logic [2:0]  s_req_l, s_ack_l;
   logic [0:0]  s_req_r, s_ack_r;
   logic [95:0] s_din;
   logic [31:0] s_dout;
   logic [2:0]  s_level;
   logic        s_full, s_err;
   // mul 8-bit, 2 in / 1 out
   logic [1:0]  m_req_l, m_ack_l;
   logic [0:0]  m_req_r, m_ack_r;
   logic [15:0] m_din;
   logic [7:0]  m_dout;
   logic [2:0]  m_level;
   logic        m_full, m_err;

   async_operator_fifo #(.data_width(32), .op("add"), .input_size(2), .output_size(2), .depth(4)) u_add (
      .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r),
      .ack_r(a_ack_r), .dout(a_dout), .level(a_level), .full(a_full), .err(a_err));
   async_operator_fifo #(.data_width(32), .op("addi"), .immediate(32'd2), .input_size(1), .output_size(2), .depth(2)) u_addi (
      .clk(clk), .rst(rst), .req_l(i_req_l), .ack_l(i_ack_l), .din(i_din), .req_r(i_req_r),
      .ack_r(i_ack_r), .dout(i_dout), .level(i_level), .full(i_full), .err(i_err));
   async_operator_fifo #(.data_width(32), .op("sub"), .input_size(3), .output_size(1), .depth(4)) u_sub (
      .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din), .req_r(s_req_r),
      .ack_r(s_ack_r), .dout(s_dout), .level(s_level), .full(s_full), .err(s_err));
   async_operator_fifo #(.data_width(8), .op("mul"), .input_size(2), .output_size(1), .depth(4)) u_mul (
      .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din), .req_r(m_req_r),
      .ack_r(m_ack_r), .dout(m_dout), .level(m_level), .full(m_full), .err(m_err));

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] q_a0[$], q_a1[$], q_i0[$], q_i1[$], q_s[$];
   logic [7:0]  q_m[$];
   int cnt_a0 = 0;
   int i_lvl_max = 0;
   logic bp_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic extra(input string name, input logic [63:0] act);
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected output %0d", name, act);
   endtask

   // Monitor: every ack_r pops the matching expected queue.
   always @(negedge clk) begin
      if (a_ack_r[0]) begin
         cnt_a0++;
         if (q_a0.size() == 0) extra("a0_extra", a_dout[31:0]);
         else check("a0_data", a_dout[31:0], q_a0.pop_front());
      end
      if (a_ack_r[1]) begin
         if (q_a1.size() == 0) extra("a1_extra", a_dout[63:32]);
         else check("a1_data", a_dout[63:32], q_a1.pop_front());
      end
      if (i_ack_r[0]) begin
         if (q_i0.size() == 0) extra("i0_extra", i_dout[31:0]);
         else check("i0_data", i_dout[31:0], q_i0.pop_front());
      end
      if (i_ack_r[1]) begin
         if (q_i1.size() == 0) extra("i1_extra", i_dout[63:32]);
         else check("i1_data", i_dout[63:32], q_i1.pop_front());
      end
      if (s_ack_r[0]) begin
         if (q_s.size() == 0) extra("s_extra", s_dout);
         else check("s_data", s_dout, q_s.pop_front());
      end
      if (m_ack_r[0]) begin
         if (q_m.size() == 0) extra("m_extra", m_dout);
         else check("m_data", m_dout, q_m.pop_front());
      end
      if (int'(i_level) > i_lvl_max) i_lvl_max = int'(i_level);
   end

   task automatic send_pair(input logic [31:0] x, input logic [31:0] y);
      int t = 0;
      while (a_req_l != 2'b11 && t < 400) begin @(negedge clk); t++; end
      check("a_req_wait", (t < 400), 1'b1);
      if (t < 400) begin
         a_din = {y, x};
         a_ack_l = 2'b11;
         q_a0.push_back(x + y);
         q_a1.push_back(x + y);
         @(negedge clk);
         a_ack_l = 2'b00;
      end
   endtask

   task automatic drive_s(input logic [95:0] v, input logic [31:0] e);
      int t = 0;
      while (s_req_l != 3'b111 && t < 100) begin @(negedge clk); t++; end
      check("s_req_wait", (t < 100), 1'b1);
      s_din = v; s_ack_l = 3'b111; q_s.push_back(e);
      @(negedge clk);
      s_ack_l = 3'b000;
   endtask

   task automatic drive_m(input logic [15:0] v, input logic [7:0] e);
      int t = 0;
      while (m_req_l != 2'b11 && t < 100) begin @(negedge clk); t++; end
      check("m_req_wait", (t < 100), 1'b1);
      m_din = v; m_ack_l = 2'b11; q_m.push_back(e);
      @(negedge clk);
      m_ack_l = 2'b00;
   endtask

   task automatic drive_i(input logic [31:0] v);
      int t = 0;
      while (i_req_l[0] != 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) extra("i_req_timeout", 64'(t));
      i_din = v; i_ack_l = 1'b1;
      q_i0.push_back(v + 32'd2);
      q_i1.push_back(v + 32'd2);
      @(negedge clk);
      i_ack_l = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((q_a0.size() + q_a1.size() + q_i0.size() + q_i1.size() + q_s.size() + q_m.size()) != 0 && t < 300) begin
         @(negedge clk); t++;
      end
      check("drain_timeout", (t < 300), 1'b1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1;
      a_ack_l = 2'b00; a_din = 64'd0; a_req_r = 2'b11;
      i_ack_l = 1'b0;  i_din = 32'd0; i_req_r = 2'b11;
      s_ack_l = 3'b000; s_din = 96'd0; s_req_r = 1'b1;
      m_ack_l = 2'b00; m_din = 16'd0; m_req_r = 1'b1;
      bp_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_l", a_req_l, 2'b00);
      check("rst_ack_r", a_ack_r, 2'b00);
      check("rst_dout", a_dout, 64'd0);
      check("rst_level", a_level, 3'd0);
      check("rst_full", a_full, 1'b0);
      check("rst_err", a_err, 1'b0);

      // release reset and fire a spurious ack on channel 0 while its req is still low
      rst = 1'b0;
      if (a_req_l[0] == 1'b0) begin
         a_din = 64'h0000_0000_DEAD_BEEF;
         a_ack_l = 2'b01;
      end
      @(negedge clk);
      a_ack_l = 2'b00;
      check("spurious_err", a_err, 1'b1);
      check("req_rise", a_req_l, 2'b11);

      // basic add with latency: ack_r two edges after the capturing edge
      send_pair(32'd5, 32'd7);
      check("lat_edge1", a_ack_r, 2'b00);
      @(negedge clk);
      check("lat_edge2", a_ack_r, 2'b00);
      check("level_one", a_level, 3'd1);
      @(negedge clk);
      check("lat_edge3", a_ack_r, 2'b11);
      send_pair(32'd10, 32'd20);
      wait_drain();
      check("level_zero", a_level, 3'd0);
      check("err_sticky", a_err, 1'b1);

      // sub fold and 8-bit mul wrap
      drive_s({32'd20, 32'd30, 32'd100}, 32'd50);
      drive_s({32'd0, 32'd10, 32'd5}, 32'hFFFF_FFFB);
      drive_m({8'd17, 8'd16}, 8'd16);
      drive_m({8'd255, 8'd255}, 8'd1);
      wait_drain();

      // output 1 stalled: fifo fills, inputs backpressured, then release
      a_req_r = 2'b01;
      t = cnt_a0;
      fork
         begin
            for (int k = 1; k <= 6; k++) send_pair(32'(k), 32'(k));
            bp_done = 1'b1;
         end
      join_none
      repeat (40) @(negedge clk);
      check("bp_out0_count", 64'(cnt_a0 - t), 64'd4);
      check("bp_full", a_full, 1'b1);
      check("bp_level", a_level, 3'd4);
      check("bp_req_l", a_req_l, 2'b00);
      a_req_r = 2'b11;
      t = 0;
      while (!(bp_done && q_a0.size() == 0 && q_a1.size() == 0) && t < 300) begin @(negedge clk); t++; end
      check("bp_drain", (t < 300), 1'b1);
      repeat (3) @(negedge clk);
      check("bp_level_end", a_level, 3'd0);
      check("bp_full_end", a_full, 1'b0);

      // addi at depth 2 with a counting producer
      for (int k = 0; k < 20; k++) drive_i(32'(k));
      wait_drain();
      check("addi_level_max_le2", (i_lvl_max <= 2), 1'b1);

      // reset mid-stream with three entries outstanding
      a_req_r = 2'b01;
      send_pair(32'd1, 32'd1);
      send_pair(32'd2, 32'd2);
      send_pair(32'd3, 32'd3);
      repeat (2) @(negedge clk);
      check("pre_rst_level", a_level, 3'd3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_level", a_level, 3'd0);
      check("mid_rst_full", a_full, 1'b0);
      check("mid_rst_ack_r", a_ack_r, 2'b00);
      check("mid_rst_dout", a_dout, 64'd0);
      check("mid_rst_req_l", a_req_l, 2'b00);
      check("mid_rst_err", a_err, 1'b0);
      q_a0.delete();
      q_a1.delete();
      @(negedge clk);
      rst = 1'b0;
      a_req_r = 2'b11;
      send_pair(32'd40, 32'd2);
      wait_drain();
      check("post_rst_level", a_level, 3'd0);

      check("left_a0", 64'(q_a0.size()), 64'd0);
      check("left_a1", 64'(q_a1.size()), 64'd0);
      check("aux_levels", {i_level, s_level, m_level}, 8'd0);
      check("aux_full", {i_full, s_full, m_full}, 3'b000);
      check("aux_err", {i_err, s_err, m_err}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
